ddr_burst_arbiter: RTL and testbench
====================================

Name: ddr_burst_arbiter

Overview:
- Shares the single DDR burst port (mem_clk domain) between three requesters: ch0 video-in write, ch1 algorithm read, ch2 video-out read.
- Arbitrates round-robin and latches the winner's address and length.
- Drives the DDR read or write request and routes DDR data handshakes back to the winner.
- Sits between the per-stream burst interfaces (e.g. the algorithm read interface) and the DDR controller.

Parameters:
- TIMEOUT_CYC, 16'd4096: max mem_clk cycles in BUSY before the burst is aborted.
- ADDR_W, 27: byte address width.
- LEN_W, 10: burst length width (64-bit words).

Ports:
- mem_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  ch0 request level; held until wr_ack.
- wr_len  in  LEN_W  ch0 burst length.
- wr_addr  in  ADDR_W  ch0 start address.
- wr_ack  out  1  ch0 grant pulse, 1 cycle.
- wr_done  out  1  ch0 burst-complete pulse, 1 cycle.
- wr_data_req  out  1  ddr_wr_data_req gated to ch0.
- rd0_req/rd0_len/rd0_addr  in  1/LEN_W/ADDR_W  ch1 request, same rules as ch0.
- rd0_ack, rd0_done, rd0_data_valid  out  1 each  ch1 grant pulse, done pulse, gated ddr_rd_data_valid.
- rd1_req/rd1_len/rd1_addr  in  1/LEN_W/ADDR_W  ch2 request.
- rd1_ack, rd1_done, rd1_data_valid  out  1 each  ch2 grant, done, gated valid.
- ddr_rd_req  out  1  DDR read burst request.
- ddr_wr_req  out  1  DDR write burst request.
- ddr_len  out  LEN_W  latched burst length.
- ddr_addr  out  ADDR_W  latched burst address.
- ddr_rd_data_valid  in  1  DDR read data strobe.
- ddr_wr_data_req  in  1  DDR write data fetch strobe.
- ddr_burst_finish  in  1  DDR end-of-burst pulse.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr=0, grant=none, timeout counter=0.
- States: IDLE, BUSY, ZLEN.
- IDLE, arbitration:
  - Search starts at rr_ptr and goes ch(rr_ptr), ch(rr_ptr+1), ch(rr_ptr+2), mod 3.
  - First channel with req=1 wins.
- IDLE, on a win with len!=0, at the same edge:
  - Register grant.
  - Pulse that channel's ack for 1 cycle.
  - Load ddr_addr and ddr_len from the winner.
  - Set ddr_wr_req (ch0) or ddr_rd_req (ch1/ch2).
  - Go to BUSY.
  - Latency: req sampled at edge n; ack, ddr_*_req, addr and len are visible after edge n.
- IDLE, on a win with len==0:
  - Pulse ack and go to ZLEN; no DDR request is issued.
  - ZLEN: pulse done, rr_ptr<=winner+1 mod 3, go to IDLE.
- BUSY:
  - ddr_*_req held high until ddr_burst_finish.
  - ddr_addr and ddr_len stay stable.
  - rdX_data_valid = ddr_rd_data_valid && grant==chX (combinational).
  - wr_data_req = ddr_wr_data_req && grant==ch0 (combinational).
  - All other channels' strobes are 0.
- BUSY, on ddr_burst_finish:
  - Clear ddr_*_req, pulse done of the grantee, rr_ptr<=grantee+1 mod 3, go to IDLE.
  - At least one IDLE cycle occurs between consecutive bursts.
- Timeout:
  - Counter increments every BUSY cycle and clears on entry to BUSY.
  - When it reaches TIMEOUT_CYC-1 without finish: clear ddr_*_req, pulse done, set timeout_err, advance rr_ptr, go to IDLE.
  - timeout_err is cleared only by rst.
- Boundary conditions:
  - ddr_burst_finish, ddr_rd_data_valid and ddr_wr_data_req in IDLE or ZLEN are ignored; nothing is forwarded.
  - Finish and timeout on the same cycle: treated as a normal finish; timeout_err is not set.
  - A req dropped before ack is withdrawn; the arbiter never acks a channel whose req is 0 at the sampling edge.
  - A req still high after done is re-arbitrated normally.
  - rst asserted mid-burst: everything returns to reset values at the next edge, and ddr_*_req falls immediately.
- Invariant: ddr_rd_req and ddr_wr_req are never both 1; at most one ack and one done per cycle.

Optional Feature:
- ARB_WR_PRIORITY_EN defined: ch0 (write) wins in IDLE whenever wr_req=1, regardless of rr_ptr. Reads round-robin between ch1 and ch2 only, via a 1-bit pointer that toggles after each read grant completes. This protects the video-in stream from overflow.
- Undefined: plain 3-way round-robin as described above.

Test Plan:
- Single read: rd0_req with len=128, addr=27'h4000000 -> rd0_ack at the next edge; ddr_rd_req=1 with ddr_len=128 and ddr_addr=27'h4000000. 128 ddr_rd_data_valid pulses appear on rd0_data_valid only. Finish -> rd0_done pulse, ddr_rd_req=0.
- All three req held high from reset -> grants in order ch0, ch1, ch2, ch0. Each burst is separated by at least 1 IDLE cycle. ddr_wr_req is set only for the ch0 grants.
- rd1 request with len=0 -> rd1_ack, then rd1_done one cycle later. ddr_rd_req and ddr_wr_req stay 0 throughout; rr_ptr moves to ch0.
- TIMEOUT_CYC=16, write granted with no finish -> ddr_wr_req drops after 16 BUSY cycles; wr_done pulses; timeout_err=1 and stays 1 until rst.
- rst=1 during BUSY with rd0 granted -> all outputs 0 after the edge. A later rd1_req is granted first because rr_ptr=0 and ch0 is idle.
- With ARB_WR_PRIORITY_EN: wr_req and rd0_req held high -> ch0 is granted every arbitration. Drop wr_req -> rd0 and rd1 alternate.

Source files
------------

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: shares one DDR burst port between three burst requesters
// (ch0 video-in write, ch1 algorithm read, ch2 video-out read).
// The arbiter is round-robin, and it latches the winner's address and length
// for the whole burst. It also routes the DDR data strobes back to the grantee
// only.
// An abort fires if DDR does not finish the burst within TIMEOUT_CYC cycles.
// Optional macro ARB_WR_PRIORITY_EN: ch0 always wins when it requests. The two
// read channels then alternate using a 1-bit pointer.
module ddr_burst_arbiter #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd4096,
   parameter int          ADDR_W      = 27,
   parameter int          LEN_W       = 10
) (
   input  logic              mem_clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [LEN_W-1:0]  wr_len,
   input  logic [ADDR_W-1:0] wr_addr,
   output logic              wr_ack,
   output logic              wr_done,
   output logic              wr_data_req,
   input  logic              rd0_req,
   input  logic [LEN_W-1:0]  rd0_len,
   input  logic [ADDR_W-1:0] rd0_addr,
   output logic              rd0_ack,
   output logic              rd0_done,
   output logic              rd0_data_valid,
   input  logic              rd1_req,
   input  logic [LEN_W-1:0]  rd1_len,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic              rd1_ack,
   output logic              rd1_done,
   output logic              rd1_data_valid,
   output logic              ddr_rd_req,
   output logic              ddr_wr_req,
   output logic [LEN_W-1:0]  ddr_len,
   output logic [ADDR_W-1:0] ddr_addr,
   input  logic              ddr_rd_data_valid,
   input  logic              ddr_wr_data_req,
   input  logic              ddr_burst_finish,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY, ZLEN} state_t;
   localparam logic [1:0] CH_NONE = 2'd3;

   state_t            state_reg, state_next;
   logic [1:0]        grant_reg, grant_next;
   logic [1:0]        rr_ptr_reg, rr_ptr_next;
   logic [15:0]       cnt_reg, cnt_next;
   logic [2:0]        ack_reg, ack_next;
   logic [2:0]        done_reg, done_next;
   logic              rd_req_reg, rd_req_next;
   logic              wr_req_reg, wr_req_next;
   logic [LEN_W-1:0]  len_reg, len_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              err_reg, err_next;
`ifdef ARB_WR_PRIORITY_EN
   logic              rd_pref_reg, rd_pref_next;   // 1: ch2 is preferred next
`endif

   logic [2:0]        req_bits;
   logic [LEN_W-1:0]  len_vec  [0:2];
   logic [ADDR_W-1:0] addr_vec [0:2];
   logic [2:0]        strobe_vec;
   logic              win_valid;
   logic [1:0]        win_ch;
   logic [2:0]        ord_sum;
   logic [1:0]        ord_idx;
   logic              end_burst;

   assign req_bits    = {rd1_req, rd0_req, wr_req};
   assign len_vec[0]  = wr_len;
   assign len_vec[1]  = rd0_len;
   assign len_vec[2]  = rd1_len;
   assign addr_vec[0] = wr_addr;
   assign addr_vec[1] = rd0_addr;
   assign addr_vec[2] = rd1_addr;

   // Data strobes reach only the current grantee, and only while a burst is active.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_strobe
         if (gi == 0) begin : g_wr
            assign strobe_vec[gi] = (state_reg == BUSY) && (grant_reg == 2'(gi)) && ddr_wr_data_req;
         end else begin : g_rd
            assign strobe_vec[gi] = (state_reg == BUSY) && (grant_reg == 2'(gi)) && ddr_rd_data_valid;
         end
      end
   endgenerate

   // Pick the winner among the live requests.
   always_comb begin
      win_valid = 1'b0;
      win_ch    = CH_NONE;
      ord_sum   = 3'd0;
      ord_idx   = 2'd0;
`ifdef ARB_WR_PRIORITY_EN
      if (wr_req) begin
         win_valid = 1'b1;
         win_ch    = 2'd0;
      end else if (rd_pref_reg ? rd1_req : rd0_req) begin
         win_valid = 1'b1;
         win_ch    = rd_pref_reg ? 2'd2 : 2'd1;
      end else if (rd_pref_reg ? rd0_req : rd1_req) begin
         win_valid = 1'b1;
         win_ch    = rd_pref_reg ? 2'd1 : 2'd2;
      end
`else
      // Scan from the farthest candidate down, so the one closest to rr_ptr wins.
      for (int k = 2; k >= 0; k--) begin
         ord_sum = {1'b0, rr_ptr_reg} + 3'(k);
         ord_idx = (ord_sum >= 3'd3) ? 2'(ord_sum - 3'd3) : ord_sum[1:0];
         if (req_bits[ord_idx]) begin
            win_valid = 1'b1;
            win_ch    = ord_idx;
         end
      end
`endif
   end

   // Next-state and registered-output logic of the arbitration FSM.
   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      rr_ptr_next = rr_ptr_reg;
      cnt_next    = cnt_reg;
      ack_next    = 3'b000;
      done_next   = 3'b000;
      rd_req_next = rd_req_reg;
      wr_req_next = wr_req_reg;
      len_next    = len_reg;
      addr_next   = addr_reg;
      err_next    = err_reg;
      end_burst   = 1'b0;
`ifdef ARB_WR_PRIORITY_EN
      rd_pref_next = rd_pref_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (win_valid) begin
               grant_next       = win_ch;
               ack_next[win_ch] = 1'b1;
               if (len_vec[win_ch] == '0) begin
                  state_next = ZLEN;
               end else begin
                  state_next  = BUSY;
                  cnt_next    = 16'd0;
                  len_next    = len_vec[win_ch];
                  addr_next   = addr_vec[win_ch];
                  wr_req_next = (win_ch == 2'd0);
                  rd_req_next = (win_ch != 2'd0);
               end
            end
         end
         BUSY: begin
            // A finish on the last allowed cycle wins over the timeout.
            if (ddr_burst_finish) begin
               end_burst = 1'b1;
            end else if (cnt_reg == TIMEOUT_CYC - 16'd1) begin
               end_burst = 1'b1;
               err_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         ZLEN: end_burst = 1'b1;
         default: state_next = IDLE;
      endcase
      if (end_burst) begin
         done_next[grant_reg] = 1'b1;
         rr_ptr_next = (grant_reg == 2'd2) ? 2'd0 : grant_reg + 2'd1;
         rd_req_next = 1'b0;
         wr_req_next = 1'b0;
         grant_next  = CH_NONE;
         state_next  = IDLE;
`ifdef ARB_WR_PRIORITY_EN
         if (grant_reg != 2'd0) rd_pref_next = (grant_reg == 2'd1);
`endif
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         grant_reg  <= CH_NONE;
         rr_ptr_reg <= 2'd0;
         cnt_reg    <= 16'd0;
         ack_reg    <= 3'b000;
         done_reg   <= 3'b000;
         rd_req_reg <= 1'b0;
         wr_req_reg <= 1'b0;
         len_reg    <= '0;
         addr_reg   <= '0;
         err_reg    <= 1'b0;
`ifdef ARB_WR_PRIORITY_EN
         rd_pref_reg <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         rr_ptr_reg <= rr_ptr_next;
         cnt_reg    <= cnt_next;
         ack_reg    <= ack_next;
         done_reg   <= done_next;
         rd_req_reg <= rd_req_next;
         wr_req_reg <= wr_req_next;
         len_reg    <= len_next;
         addr_reg   <= addr_next;
         err_reg    <= err_next;
`ifdef ARB_WR_PRIORITY_EN
         rd_pref_reg <= rd_pref_next;
`endif
      end
   end

   // DDR requests drop as soon as rst rises, without waiting for the edge.
   assign ddr_rd_req     = rd_req_reg & ~rst;
   assign ddr_wr_req     = wr_req_reg & ~rst;
   assign ddr_len        = len_reg;
   assign ddr_addr       = addr_reg;
   assign timeout_err    = err_reg;
   assign wr_ack         = ack_reg[0];
   assign rd0_ack        = ack_reg[1];
   assign rd1_ack        = ack_reg[2];
   assign wr_done        = done_reg[0];
   assign rd0_done       = done_reg[1];
   assign rd1_done       = done_reg[2];
   assign wr_data_req    = strobe_vec[0];
   assign rd0_data_valid = strobe_vec[1];
   assign rd1_data_valid = strobe_vec[2];

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Testbench for ddr_burst_arbiter (built with TIMEOUT_CYC=16).
// A transaction-level reference model predicts every output each cycle.
// Directed checks come first and pin the model. Randomized requesters and a
// random DDR side follow.
module tb_ddr_burst_arbiter;
   localparam int ADDR_W = 27;
   localparam int LEN_W  = 10;
   localparam int T      = 16;

   logic mem_clk = 1'b0;
   logic rst = 1'b1;
   always #5 mem_clk = ~mem_clk;

   logic [2:0]        req_s;
   logic [LEN_W-1:0]  len_s  [3];
   logic [ADDR_W-1:0] addr_s [3];
   logic ddr_rd_data_valid, ddr_wr_data_req, ddr_burst_finish;
   logic wr_ack, wr_done, wr_data_req, rd0_ack, rd0_done, rd0_data_valid;
   logic rd1_ack, rd1_done, rd1_data_valid, ddr_rd_req, ddr_wr_req, timeout_err;
   logic [LEN_W-1:0]  ddr_len;
   logic [ADDR_W-1:0] ddr_addr;

   ddr_burst_arbiter #(.TIMEOUT_CYC(16'(T)), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .mem_clk(mem_clk), .rst(rst),
      .wr_req(req_s[0]), .wr_len(len_s[0]), .wr_addr(addr_s[0]),
      .wr_ack(wr_ack), .wr_done(wr_done), .wr_data_req(wr_data_req),
      .rd0_req(req_s[1]), .rd0_len(len_s[1]), .rd0_addr(addr_s[1]),
      .rd0_ack(rd0_ack), .rd0_done(rd0_done), .rd0_data_valid(rd0_data_valid),
      .rd1_req(req_s[2]), .rd1_len(len_s[2]), .rd1_addr(addr_s[2]),
      .rd1_ack(rd1_ack), .rd1_done(rd1_done), .rd1_data_valid(rd1_data_valid),
      .ddr_rd_req(ddr_rd_req), .ddr_wr_req(ddr_wr_req),
      .ddr_len(ddr_len), .ddr_addr(ddr_addr),
      .ddr_rd_data_valid(ddr_rd_data_valid), .ddr_wr_data_req(ddr_wr_data_req),
      .ddr_burst_finish(ddr_burst_finish), .timeout_err(timeout_err)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 no burst, 1 DDR burst running, 2 zero-length grant pending done
   int m_phase, m_ptr, m_g, m_n;
   logic [2:0] m_ack, m_done;
   logic m_rdq, m_wrq, m_err, m_pref;
   logic [LEN_W-1:0]  m_len;
   logic [ADDR_W-1:0] m_addr;
   bit chk_en = 1'b0;

   function automatic int pick();
`ifdef ARB_WR_PRIORITY_EN
      int first = m_pref ? 2 : 1;
      if (req_s[0]) return 0;
      if (req_s[first]) return first;
      if (req_s[3 - first]) return 3 - first;
      return 3;
`else
      for (int k = 0; k < 3; k++) begin
         int c = (m_ptr + k) % 3;
         if (req_s[c]) return c;
      end
      return 3;
`endif
   endfunction

   task automatic end_burst();
      m_done[m_g] = 1'b1;
      m_ptr = (m_g + 1) % 3;
      if (m_g != 0) m_pref = (m_g == 1);
      m_phase = 0;
      m_rdq = 1'b0;
      m_wrq = 1'b0;
      m_g = 3;
   endtask

   always @(posedge mem_clk) begin
      int w;
      m_ack  = 3'b000;
      m_done = 3'b000;
      if (rst) begin
         m_phase = 0; m_ptr = 0; m_g = 3; m_n = 0;
         m_rdq = 1'b0; m_wrq = 1'b0; m_err = 1'b0; m_pref = 1'b0;
         m_len = '0; m_addr = '0;
         chk_en = 1'b1;
      end else if (m_phase == 0) begin
         w = pick();
         if (w < 3) begin
            m_ack[w] = 1'b1;
            m_g = w;
            $display("[TB] t=%0t grant ch%0d len=%0d addr=%0h", $time, w, len_s[w], addr_s[w]);
            if (len_s[w] == 0) begin
               m_phase = 2;
            end else begin
               m_phase = 1; m_n = 0;
               m_len = len_s[w]; m_addr = addr_s[w];
               m_wrq = (w == 0); m_rdq = (w != 0);
            end
         end
      end else if (m_phase == 1) begin
         if (ddr_burst_finish) end_burst();
         else if (m_n == T - 1) begin m_err = 1'b1; end_burst(); end
         else m_n++;
      end else begin
         end_burst();
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge mem_clk) begin
      if (chk_en) begin
         check("ack", 64'({rd1_ack, rd0_ack, wr_ack}), 64'(m_ack));
         check("done", 64'({rd1_done, rd0_done, wr_done}), 64'(m_done));
         check("ddr_rd_req", 64'(ddr_rd_req), 64'(m_rdq && !rst));
         check("ddr_wr_req", 64'(ddr_wr_req), 64'(m_wrq && !rst));
         check("ddr_len", 64'(ddr_len), 64'(m_len));
         check("ddr_addr", 64'(ddr_addr), 64'(m_addr));
         check("timeout_err", 64'(timeout_err), 64'(m_err));
         check("strobes", 64'({rd1_data_valid, rd0_data_valid, wr_data_req}),
               64'({m_phase == 1 && m_g == 2 && ddr_rd_data_valid,
                    m_phase == 1 && m_g == 1 && ddr_rd_data_valid,
                    m_phase == 1 && m_g == 0 && ddr_wr_data_req}));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic new_req(input int c);
      req_s[c]  = 1'b1;
      len_s[c]  = ($urandom_range(0, 4) == 0) ? '0 : LEN_W'($urandom_range(1, 8));
      addr_s[c] = ADDR_W'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[$];
      int exp_order[4];
      int fcnt, dcnt, target, ch;
      logic ackc, busy, busy_prev;
      req_s = 3'b000;
      for (int c = 0; c < 3; c++) begin len_s[c] = '0; addr_s[c] = '0; end
      ddr_rd_data_valid = 1'b0; ddr_wr_data_req = 1'b0; ddr_burst_finish = 1'b0;
      repeat (3) step();
      check("reset_outputs", 64'({wr_ack, wr_done, wr_data_req, rd0_ack, rd0_done, rd0_data_valid,
            rd1_ack, rd1_done, rd1_data_valid, ddr_rd_req, ddr_wr_req, timeout_err, ddr_len, ddr_addr}), 64'd0);
      rst = 1'b0;

      // single read on ch1
      req_s[1] = 1'b1; len_s[1] = 10'd128; addr_s[1] = 27'h4000000;
      step();
      check("rd0_ack_pulse", 64'(rd0_ack), 64'd1);
      check("rd_req_set", 64'({ddr_rd_req, ddr_wr_req}), 64'b10);
      check("ddr_len_128", 64'(ddr_len), 64'd128);
      check("ddr_addr_lat", 64'(ddr_addr), 64'h4000000);
      req_s[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ddr_rd_data_valid = 1'b1;
         #1;
         check("rd0_valid_only", 64'({rd1_data_valid, rd0_data_valid, wr_data_req}), 64'b010);
         step();
      end
      ddr_rd_data_valid = 1'b0; ddr_burst_finish = 1'b1;
      step();
      check("rd0_done_pulse", 64'(rd0_done), 64'd1);
      check("rd_req_cleared", 64'(ddr_rd_req), 64'd0);
      // strobes and finish while idle are ignored
      ddr_rd_data_valid = 1'b1; ddr_wr_data_req = 1'b1; ddr_burst_finish = 1'b1;
      #1;
      check("idle_strobes", 64'({rd1_data_valid, rd0_data_valid, wr_data_req}), 64'd0);
      step();
      check("idle_finish_ignored", 64'({rd1_done, rd0_done, wr_done, ddr_rd_req, ddr_wr_req}), 64'd0);
      ddr_rd_data_valid = 1'b0; ddr_wr_data_req = 1'b0; ddr_burst_finish = 1'b0;

      // zero-length request on ch2
      req_s[2] = 1'b1; len_s[2] = '0; addr_s[2] = 27'h5;
      step();
      check("zlen_ack", 64'(rd1_ack), 64'd1);
      check("zlen_no_ddr", 64'({ddr_rd_req, ddr_wr_req}), 64'd0);
      req_s[2] = 1'b0;
      step();
      check("zlen_done", 64'({rd1_done, rd1_ack}), 64'b10);
      check("zlen_no_ddr2", 64'({ddr_rd_req, ddr_wr_req}), 64'd0);

      // ch0 and ch2 together: pointer is at ch0, so write wins; no finish -> timeout
      req_s[0] = 1'b1; len_s[0] = 10'd5; addr_s[0] = 27'h123;
      req_s[2] = 1'b1; len_s[2] = 10'd4;
      step();
      check("ptr_ch0_wins", 64'({rd1_ack, rd0_ack, wr_ack}), 64'b001);
      check("wr_req_set", 64'(ddr_wr_req), 64'd1);
      req_s[0] = 1'b0; req_s[2] = 1'b0;
      for (int i = 1; i < T; i++) begin
         step();
         check("wr_held", 64'(ddr_wr_req), 64'd1);
      end
      step();
      check("timeout_drop", 64'({ddr_wr_req, wr_done, timeout_err}), 64'b011);
      repeat (5) step();
      check("timeout_sticky", 64'(timeout_err), 64'd1);

      // reset in the middle of a ch1 burst
      req_s[1] = 1'b1; len_s[1] = 10'd10; addr_s[1] = 27'h55;
      step();
      check("rst_test_ack", 64'(rd0_ack), 64'd1);
      req_s[1] = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check("rst_req_falls", 64'(ddr_rd_req), 64'd0);
      step();
      check("rst_outputs", 64'({wr_ack, wr_done, rd0_ack, rd0_done, rd1_ack, rd1_done,
            ddr_rd_req, ddr_wr_req, timeout_err, ddr_len, ddr_addr}), 64'd0);
      rst = 1'b0;
      req_s[2] = 1'b1; len_s[2] = 10'd3; addr_s[2] = 27'h77;
      step();
      check("post_rst_rd1_ack", 64'(rd1_ack), 64'd1);
      req_s[2] = 1'b0; ddr_burst_finish = 1'b1;
      step();
      check("post_rst_rd1_done", 64'(rd1_done), 64'd1);
      ddr_burst_finish = 1'b0;

      // all three held high: grant order
      req_s = 3'b111;
      for (int c = 0; c < 3; c++) len_s[c] = 10'd4;
      fcnt = 0;
      for (int cyc = 0; cyc < 200 && order.size() < 4; cyc++) begin
         step();
         ddr_burst_finish = 1'b0;
         if ({rd1_ack, rd0_ack, wr_ack} != 3'b000) begin
            ch = rd0_ack ? 1 : (rd1_ack ? 2 : 0);
            order.push_back(ch);
            check("wr_req_only_ch0", 64'(ddr_wr_req), 64'(ch == 0));
         end
         if (ddr_rd_req || ddr_wr_req) begin
            fcnt++;
            if (fcnt == 3) begin ddr_burst_finish = 1'b1; fcnt = 0; end
         end
      end
`ifdef ARB_WR_PRIORITY_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 0};
`endif
      check("rr_grant_count", 64'(order.size()), 64'd4);
      if (order.size() == 4)
         for (int i = 0; i < 4; i++) check("rr_order", 64'(order[i]), 64'(exp_order[i]));
      req_s = 3'b000;
      ddr_burst_finish = 1'b0;

      // randomized traffic
      busy_prev = 1'b0; dcnt = 0; target = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         for (int c = 0; c < 3; c++) begin
            ackc = (c == 0) ? wr_ack : ((c == 1) ? rd0_ack : rd1_ack);
            if (ackc) begin
               if ($urandom_range(0, 1) == 1) req_s[c] = 1'b0;
               else new_req(c);
            end else if (req_s[c] && $urandom_range(0, 19) == 0) begin
               req_s[c] = 1'b0;
            end else if (!req_s[c] && $urandom_range(0, 5) == 0) begin
               new_req(c);
            end
         end
         busy = ddr_rd_req || ddr_wr_req;
         if (busy && !busy_prev) begin dcnt = 0; target = $urandom_range(0, 21); end
         else if (busy) dcnt++;
         ddr_burst_finish  = busy ? (dcnt == target) : ($urandom_range(0, 7) == 0);
         busy_prev         = busy;
         ddr_rd_data_valid = ($urandom_range(0, 1) == 1);
         ddr_wr_data_req   = ($urandom_range(0, 1) == 1);
         rst               = ($urandom_range(0, 399) == 0);
      end
      rst = 1'b0; req_s = 3'b000; ddr_burst_finish = 1'b0;
      repeat (4) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
